// File: rtl/rsa_stream_ctrl_if.sv
// rsa_stream_ctrl_if: key inputs, plaintext byte stream, result word stream
// and exponentiator handshake of the RSA stream controller.
interface rsa_stream_ctrl_if #(
    parameter int BUS_WIDTH = 16
);
    logic [BUS_WIDTH-1:0] e;
    logic [BUS_WIDTH-1:0] n;
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_last;
    logic                 out_err;
    logic                 out_ready;
    logic [BUS_WIDTH-1:0] exp_m;
    logic [BUS_WIDTH-1:0] exp_e;
    logic [BUS_WIDTH-1:0] exp_n;
    logic                 exp_start;
    logic [BUS_WIDTH-1:0] exp_result;
    logic                 exp_valid;

    modport master (
        output e, n, in_data, in_valid, in_last, out_ready, exp_result, exp_valid,
        input  in_ready, out_data, out_valid, out_last, out_err, exp_m, exp_e, exp_n, exp_start
    );

    modport slave (
        input  e, n, in_data, in_valid, in_last, out_ready, exp_result, exp_valid,
        output in_ready, out_data, out_valid, out_last, out_err, exp_m, exp_e, exp_n, exp_start
    );
endinterface

// File: rtl/rsa_stream_ctrl.sv
// rsa_stream_ctrl: packs plaintext bytes into words, range-checks them against
// the latched modulus and sequences one exponentiation per word.
module rsa_stream_ctrl #(
    parameter int BUS_WIDTH     = 16,
    parameter int COUNTER_WIDTH = 4
) (
    input logic              clk,
    input logic              reset,
    rsa_stream_ctrl_if.slave bus
);
    typedef enum logic [2:0] {COLLECT, START, WAIT, CAPTURE, OUTPUT} state_t;

    state_t                   state;
    state_t                   state_nx;
    logic [COUNTER_WIDTH-4:0] cnt;
    logic [BUS_WIDTH-1:0]     word;
    logic [BUS_WIDTH-1:0]     word_nx;
    logic [BUS_WIDTH-1:0]     key_e;
    logic [BUS_WIDTH-1:0]     key_n;
    logic [BUS_WIDTH-1:0]     data_r;
    logic                     open;
    logic                     last_r;
    logic                     err_r;
    logic                     accept;
    logic                     done;
    logic                     oor;
    logic                     hs;

    assign accept  = state == COLLECT && bus.in_valid;
    assign done    = accept && (bus.in_last || &cnt);
    // A fresh word starts from zero so an early in_last leaves low bytes clear
    assign word_nx = (cnt == '0 ? '0 : word) | (BUS_WIDTH'(bus.in_data) << {~cnt, 3'b000});
    // The first byte of a message is checked against n before it is latched
    assign oor     = word_nx >= (open ? key_n : bus.n);
    assign hs      = state == OUTPUT && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= COLLECT;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: if (done) state_nx = oor ? OUTPUT : START;
            START:   state_nx = WAIT;
            WAIT:    if (bus.exp_valid) state_nx = CAPTURE;
            CAPTURE: state_nx = OUTPUT;
            OUTPUT:  if (bus.out_ready) state_nx = COLLECT;
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            word   <= '0;
            key_e  <= '0;
            key_n  <= '0;
            data_r <= '0;
            open   <= 1'b0;
            last_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            if (accept) begin
                cnt  <= cnt + 1'b1;
                word <= word_nx;
                if (!open) begin
                    key_e <= bus.e;
                    key_n <= bus.n;
                    open  <= 1'b1;
                end
            end
            if (done) begin
                last_r <= bus.in_last;
                data_r <= word_nx;
                err_r  <= oor;
            end
            // exp_result settles one cycle after exp_valid, i.e. during CAPTURE
            if (state == CAPTURE) begin
                data_r <= bus.exp_result;
                err_r  <= 1'b0;
            end
            if (hs) begin
                cnt    <= '0;
                last_r <= 1'b0;
                err_r  <= 1'b0;
                if (last_r) open <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = state == COLLECT;
    assign bus.exp_start = state == START;
    assign bus.out_valid = state == OUTPUT;
    assign bus.out_data  = data_r;
    assign bus.out_last  = last_r;
    assign bus.out_err   = err_r;
    assign bus.exp_m     = word;
    assign bus.exp_e     = key_e;
    assign bus.exp_n     = key_n;
endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// tb_rsa_stream_ctrl: directed checks of the RSA stream controller against a
// behavioural square-and-multiply responder.
module tb_rsa_stream_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   starts = 0;
    logic [15:0] rm, re, rn;

    rsa_stream_ctrl_if #(.BUS_WIDTH(16)) bus ();

    rsa_stream_ctrl #(.BUS_WIDTH(16), .COUNTER_WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] modexp(input logic [15:0] b, input logic [15:0] ee, input logic [15:0] nn);
        longint r = 1;
        longint x = longint'(b) % longint'(nn);
        for (int i = 0; i < 16; i++) begin
            if (ee[i]) r = (r * x) % longint'(nn);
            x = (x * x) % longint'(nn);
        end
        return 16'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t = 0;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_out();
        int t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("out_valid_wait", 32'(bus.out_valid), 1);
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("post_hs_in_ready", 32'(bus.in_ready), 1);
        chk("post_hs_out_valid", 32'(bus.out_valid), 0);
    endtask

    // Exponentiator stand-in: result is junk while exp_valid is high, final a cycle later
    always begin
        @(negedge clk);
        if (bus.exp_start) begin
            rm = bus.exp_m;
            re = bus.exp_e;
            rn = bus.exp_n;
            repeat (3) @(posedge clk);
            #1 bus.exp_valid = 1'b1;
            bus.exp_result = 16'hDEAD;
            @(posedge clk);
            #1 bus.exp_valid = 1'b0;
            bus.exp_result = modexp(rm, re, rn);
        end
    end

    always @(negedge clk) if (bus.exp_start) starts++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.e = 16'd17;
        bus.n = 16'd3233;
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        bus.exp_valid = 1'b0;
        bus.exp_result = 16'h0000;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_exp_start", 32'(bus.exp_start), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_err", 32'(bus.out_err), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_exp_e", 32'(bus.exp_e), 0);

        // single word 0x0041, e=17, n=3233
        send_byte(8'h00, 1'b0);
        send_byte(8'h41, 1'b1);
        chk("t1_exp_start", 32'(bus.exp_start), 1);
        chk("t1_exp_m", 32'(bus.exp_m), 32'h0041);
        chk("t1_exp_e", 32'(bus.exp_e), 17);
        chk("t1_exp_n", 32'(bus.exp_n), 3233);
        @(negedge clk);
        chk("t1_start_one_cycle", 32'(bus.exp_start), 0);
        wait_out();
        chk("t1_out_data", 32'(bus.out_data), 2790);
        chk("t1_out_last", 32'(bus.out_last), 1);
        chk("t1_out_err", 32'(bus.out_err), 0);
        chk("t1_starts", 32'(starts), 1);
        handshake();

        // out-of-range word with 10 cycles of backpressure
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b1);
        chk("t2_exp_start", 32'(bus.exp_start), 0);
        chk("t2_out_last", 32'(bus.out_last), 1);
        for (int i = 0; i < 10; i++) begin
            chk("t2_bp_out_valid", 32'(bus.out_valid), 1);
            chk("t2_bp_out_data", 32'(bus.out_data), 32'hFFFF);
            chk("t2_bp_out_err", 32'(bus.out_err), 1);
            chk("t2_bp_in_ready", 32'(bus.in_ready), 0);
            @(negedge clk);
        end
        chk("t2_starts", 32'(starts), 1);
        handshake();

        // partial word: one byte with in_last
        send_byte(8'h01, 1'b1);
        chk("t3_exp_m", 32'(bus.exp_m), 32'h0100);
        chk("t3_exp_start", 32'(bus.exp_start), 1);
        wait_out();
        chk("t3_out_data", 32'(bus.out_data), 32'(modexp(16'h0100, 16'd17, 16'd3233)));
        chk("t3_out_last", 32'(bus.out_last), 1);
        chk("t3_out_err", 32'(bus.out_err), 0);
        handshake();

        // key inputs change after the first byte of a two-word message
        send_byte(8'h00, 1'b0);
        bus.e = 16'd3;
        bus.n = 16'd5;
        send_byte(8'h41, 1'b0);
        chk("t4_w1_exp_e", 32'(bus.exp_e), 17);
        wait_out();
        chk("t4_w1_out_data", 32'(bus.out_data), 2790);
        chk("t4_w1_out_last", 32'(bus.out_last), 0);
        handshake();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b1);
        chk("t4_w2_exp_e", 32'(bus.exp_e), 17);
        chk("t4_w2_exp_n", 32'(bus.exp_n), 3233);
        wait_out();
        chk("t4_w2_out_data", 32'(bus.out_data), 1752);
        chk("t4_w2_out_last", 32'(bus.out_last), 1);
        chk("t4_w2_out_err", 32'(bus.out_err), 0);
        handshake();
        bus.e = 16'd17;
        bus.n = 16'd3233;

        // reset while waiting on the exponentiator
        send_byte(8'h00, 1'b0);
        send_byte(8'h41, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_in_ready", 32'(bus.in_ready), 1);
        chk("t5_out_valid", 32'(bus.out_valid), 0);
        chk("t5_out_data", 32'(bus.out_data), 0);
        chk("t5_out_last", 32'(bus.out_last), 0);
        chk("t5_exp_start", 32'(bus.exp_start), 0);
        chk("t5_exp_m", 32'(bus.exp_m), 0);
        chk("t5_exp_n", 32'(bus.exp_n), 0);
        repeat (6) @(negedge clk);
        chk("t5_late_valid_ignored", 32'(bus.out_valid), 0);
        chk("t5_idle_in_ready", 32'(bus.in_ready), 1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h41, 1'b1);
        wait_out();
        chk("t5_out_data", 32'(bus.out_data), 2790);
        chk("t5_out_last_after", 32'(bus.out_last), 1);
        chk("t5_out_err_after", 32'(bus.out_err), 0);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
